// File: rtl/oak_const_streamer.sv
// oak_const_streamer: snapshots the five L1 constants on start and emits them as one
// framed 32-bit word stream (header, 9 data words, optional XOR checksum). Build option: OAK_STREAM_CSUM_EN.
//
// state | meaning
// IDLE  | no frame in flight, waiting for start
// HDR   | presenting header {MAGIC, seq_num, 8'd9}
// DATA  | presenting data word r_idx (0..8) from the snapshot
// CSUM  | presenting XOR checksum of the data words (OAK_STREAM_CSUM_EN only)

module oak_const_streamer #(
   parameter logic [15:0] MAGIC    = 16'h0AC0,
   parameter bit          HI_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] phi,
   input  logic [63:0] pi,
   input  logic [63:0] e,
   input  logic [63:0] trinity,
   input  logic [31:0] phoenix_id,
   input  logic        start,
   output logic [31:0] tdata,
   output logic        tvalid,
   input  logic        tready,
   output logic        tlast,
   output logic        busy,
   output logic        frame_done,
   output logic [7:0]  seq_num
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HDR  = 2'd1,
      S_DATA = 2'd2,
      S_CSUM = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_idx;
   logic [63:0] r_phi;
   logic [63:0] r_pi;
   logic [63:0] r_e;
   logic [63:0] r_trinity;
   logic [31:0] r_phoenix_id;
   logic [7:0]  r_seq;
   logic        r_frame_done;
`ifdef OAK_STREAM_CSUM_EN
   logic [31:0] r_csum;
`endif

   logic [63:0] w_const;
   logic        w_take_hi;
   logic [31:0] w_data_word;
   logic [31:0] w_tdata;
   logic        w_tlast;
   logic        w_tvalid;
   logic        w_hs;
   logic        w_capture;
   logic        w_frame_end;

   // Data order: idx[2:1] picks the constant, idx[0] picks which half goes first.
   always_comb begin
      w_const = r_phi;
      case (r_idx[2:1])
         2'd0:    w_const = r_phi;
         2'd1:    w_const = r_pi;
         2'd2:    w_const = r_e;
         default: w_const = r_trinity;
      endcase
   end

   assign w_take_hi   = r_idx[0] ^ HI_FIRST;
   assign w_data_word = (r_idx == 4'd8) ? r_phoenix_id
                      : (w_take_hi ? w_const[63:32] : w_const[31:0]);

   assign w_tvalid    = (r_state != S_IDLE);
   assign w_hs        = w_tvalid && tready;
   assign w_capture   = (r_state == S_IDLE) && start;
   assign w_frame_end = w_hs && w_tlast;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tdata     = 32'd0;
      w_tlast     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_HDR;
            end
         end
         S_HDR: begin
            w_tdata = {MAGIC, r_seq, 8'd9};
            if (tready) begin
               w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            w_tdata = w_data_word;
`ifdef OAK_STREAM_CSUM_EN
            if (tready && (r_idx == 4'd8)) begin
               w_state_nxt = S_CSUM;
            end
`else
            w_tlast = (r_idx == 4'd8);
            if (tready && (r_idx == 4'd8)) begin
               w_state_nxt = S_IDLE;
            end
`endif
         end
`ifdef OAK_STREAM_CSUM_EN
         S_CSUM: begin
            w_tdata = r_csum;
            w_tlast = 1'b1;
            if (tready) begin
               w_state_nxt = S_IDLE;
            end
         end
`endif
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx        <= 4'd0;
         r_phi        <= 64'd0;
         r_pi         <= 64'd0;
         r_e          <= 64'd0;
         r_trinity    <= 64'd0;
         r_phoenix_id <= 32'd0;
         r_seq        <= 8'd0;
         r_frame_done <= 1'b0;
`ifdef OAK_STREAM_CSUM_EN
         r_csum       <= 32'd0;
`endif
      end else begin
         r_frame_done <= w_frame_end;
         if (w_frame_end) begin
            r_seq <= r_seq + 8'd1;
         end
         if (w_capture) begin
            r_phi        <= phi;
            r_pi         <= pi;
            r_e          <= e;
            r_trinity    <= trinity;
            r_phoenix_id <= phoenix_id;
`ifdef OAK_STREAM_CSUM_EN
            r_csum       <= 32'd0;
`endif
         end
         if (w_hs && (r_state == S_HDR)) begin
            r_idx <= 4'd0;
         end
         if (w_hs && (r_state == S_DATA)) begin
            r_idx <= r_idx + 4'd1;
`ifdef OAK_STREAM_CSUM_EN
            r_csum <= r_csum ^ w_data_word;
`endif
         end
      end
   end

   assign tdata      = w_tdata;
   assign tvalid     = w_tvalid;
   assign tlast      = w_tlast;
   assign busy       = w_tvalid;
   assign frame_done = r_frame_done;
   assign seq_num    = r_seq;

endmodule

// File: tb/tb_oak_const_streamer.sv
// Bench for oak_const_streamer: two instances (hi-first and lo-first) in lockstep,
// checked every cycle against a frame-level word-queue model built at start acceptance.

module tb_oak_const_streamer;

`ifdef OAK_STREAM_CSUM_EN
   localparam int NW = 11;
`else
   localparam int NW = 10;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] phi, pi, e, trinity;
   logic [31:0] phoenix_id;
   logic        start;
   logic        tready;

   logic [31:0] tdata, tdata_lo;
   logic        tvalid, tvalid_lo, tlast, tlast_lo, busy, busy_lo;
   logic        frame_done, frame_done_lo;
   logic [7:0]  seq_num, seq_num_lo;

   always #5 clk = ~clk;

   oak_const_streamer u_dut (
      .clk(clk), .rst(rst), .phi(phi), .pi(pi), .e(e), .trinity(trinity),
      .phoenix_id(phoenix_id), .start(start), .tdata(tdata), .tvalid(tvalid),
      .tready(tready), .tlast(tlast), .busy(busy), .frame_done(frame_done),
      .seq_num(seq_num)
   );

   oak_const_streamer #(.HI_FIRST(1'b0)) u_dut_lo (
      .clk(clk), .rst(rst), .phi(phi), .pi(pi), .e(e), .trinity(trinity),
      .phoenix_id(phoenix_id), .start(start), .tdata(tdata_lo), .tvalid(tvalid_lo),
      .tready(tready), .tlast(tlast_lo), .busy(busy_lo), .frame_done(frame_done_lo),
      .seq_num(seq_num_lo)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [31:0] w_hi;
      logic [31:0] w_lo;
      logic        last;
   } exp_t;

   exp_t        q[$];
   logic [31:0] got_hi[$];
   logic [31:0] got_lo[$];
   bit          m_busy = 0;
   bit          m_done = 0;
   logic [7:0]  m_seq = 8'd0;
   int          frm_words = 0;
   int          frames_done = 0;
   logic [31:0] last_hdr = 32'd0;

   task automatic push_frame(input logic [63:0] c0, input logic [63:0] c1,
                             input logic [63:0] c2, input logic [63:0] c3,
                             input logic [31:0] pid, input logic [7:0] sq);
      logic [63:0] c[4];
      logic [31:0] cs;
      logic [31:0] hdr;
      c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
      cs = 32'd0;
      hdr = {16'h0AC0, sq, 8'd9};
      q.push_back('{hdr, hdr, 1'b0});
      for (int k = 0; k < 4; k++) begin
         q.push_back('{c[k][63:32], c[k][31:0], 1'b0});
         q.push_back('{c[k][31:0], c[k][63:32], 1'b0});
         cs = cs ^ c[k][63:32] ^ c[k][31:0];
      end
      cs = cs ^ pid;
`ifdef OAK_STREAM_CSUM_EN
      q.push_back('{pid, pid, 1'b0});
      q.push_back('{cs, cs, 1'b1});
`else
      q.push_back('{pid, pid, 1'b1});
`endif
   endtask

   always @(negedge clk) begin
      exp_t ex;
      bit   was_busy;
      bit   done_nxt;
      if (rst) begin
         chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
         chk("rst_seq", {24'd0, seq_num}, 32'd0);
         q.delete();
         m_busy = 0;
         m_done = 0;
         m_seq = 8'd0;
         frm_words = 0;
      end else begin
         chk("tvalid", {30'd0, tvalid_lo, tvalid}, {30'd0, m_busy, m_busy});
         chk("busy", {30'd0, busy_lo, busy}, {30'd0, m_busy, m_busy});
         chk("frame_done", {30'd0, frame_done_lo, frame_done}, {30'd0, m_done, m_done});
         chk("seq_num", {16'd0, seq_num_lo, seq_num}, {16'd0, m_seq, m_seq});
         if (m_busy && q.size() > 0) begin
            chk("tdata_hi", tdata, q[0].w_hi);
            chk("tdata_lo", tdata_lo, q[0].w_lo);
            chk("tlast", {30'd0, tlast_lo, tlast}, {30'd0, q[0].last, q[0].last});
         end
         was_busy = m_busy;
         done_nxt = 0;
         if (m_busy && tready && q.size() > 0) begin
            ex = q.pop_front();
            got_hi.push_back(tdata);
            got_lo.push_back(tdata_lo);
            if (frm_words == 0) last_hdr = tdata;
            frm_words++;
            if (ex.last) begin
               m_busy = 0;
               done_nxt = 1;
               m_seq = m_seq + 8'd1;
               frames_done++;
            end
         end
         if (!was_busy && start) begin
            push_frame(phi, pi, e, trinity, phoenix_id, m_seq);
            m_busy = 1;
            frm_words = 0;
         end
         m_done = done_nxt;
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic pick_ready(input int mode, input int cyc);
      if (mode == 1) return ((cyc % 4) == 0) || ((cyc % 4) == 3);
      if (mode == 2) return ($urandom_range(0, 3) != 0);
      return 1'b1;
   endfunction

   // act: 0 none, 1 phi<=0 at word trig, 2 start pulse at word trig, 3 reset at word trig, 4 start on tlast
   task automatic run_frame(input int mode, input int act, input int trig);
      int f0;
      int cyc;
      bit fired;
      f0 = frames_done;
      cyc = 0;
      fired = 0;
      @(posedge clk); #1;
      start = 1'b1;
      tready = pick_ready(mode, 0);
      @(posedge clk); #1;
      start = 1'b0;
      while (frames_done == f0 && cyc < 400) begin
         start = 1'b0;
         tready = pick_ready(mode, cyc);
         if (!fired && act == 1 && frm_words == trig) begin
            phi = 64'd0; fired = 1;
         end
         if (!fired && act == 2 && frm_words == trig) begin
            start = 1'b1; fired = 1;
         end
         if (!fired && act == 4 && tlast && tvalid) begin
            start = 1'b1; tready = 1'b1; fired = 1;
         end
         if (!fired && act == 3 && frm_words == trig) begin
            rst = 1'b1;
            #1;
            chk("midrst_tvalid", {30'd0, tvalid_lo, tvalid}, 32'd0);
            chk("midrst_seq", {24'd0, seq_num}, 32'd0);
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            return;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      if (cyc >= 400) chk("frame_timeout", 32'(cyc), 32'd0);
   endtask

   logic [31:0] lit[11];
   logic [63:0] phi_tp;

   initial begin
      lit = '{32'h0AC00009, 32'h3FF9E377, 32'h9B97F4A8, 32'h400921FB, 32'h54442D18,
              32'h4005BF0A, 32'h8B145769, 32'h40080000, 32'h00000000, 32'h000003E7,
              32'h3B3AF0B8};
      phi_tp     = 64'h3FF9E3779B97F4A8;
      phi        = phi_tp;
      pi         = 64'h400921FB54442D18;
      e          = 64'h4005BF0A8B145769;
      trinity    = 64'h4008000000000000;
      phoenix_id = 32'h000003E7;
      start      = 1'b0;
      tready     = 1'b0;
      rst        = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", {tdata[31:0]}, 32'd0);
      chk("reset_flags", {28'd0, tvalid, tlast, busy, frame_done}, 32'd0);
      rst = 1'b0;

      // test-plan frame, tready held high
      got_hi.delete(); got_lo.delete();
      run_frame(0, 0, 0);
      chk("tp_len", 32'(got_hi.size()), 32'(NW));
      for (int i = 0; i < NW && i < got_hi.size(); i++) chk($sformatf("tp_word%0d", i), got_hi[i], lit[i]);
      if (got_lo.size() > 2) chk("lo_word1", got_lo[1], 32'h9B97F4A8);
`ifndef OAK_STREAM_CSUM_EN
      if (got_lo.size() >= 10) chk("lo_word9", got_lo[9], 32'h000003E7);
`endif
      @(posedge clk); #1;
      chk("tp_seq", {24'd0, seq_num}, 32'd1);

      // backpressure 1,0,0,1
      got_hi.delete(); got_lo.delete();
      run_frame(1, 0, 0);
      chk("bp_len", 32'(got_hi.size()), 32'(NW));
      if (got_hi.size() > 0) chk("bp_hdr", got_hi[0], 32'h0AC00109);
      for (int i = 1; i < NW && i < got_hi.size(); i++) chk($sformatf("bp_word%0d", i), got_hi[i], lit[i]);

      // snapshot: phi changes at DATA index 3
      got_hi.delete(); got_lo.delete();
      run_frame(0, 1, 4);
      if (got_hi.size() > 2) begin
         chk("snap_phi_hi", got_hi[1], 32'h3FF9E377);
         chk("snap_phi_lo", got_hi[2], 32'h9B97F4A8);
      end
      got_hi.delete(); got_lo.delete();
      run_frame(0, 0, 0);
      if (got_hi.size() > 2) chk("snap_next", got_hi[1] | got_hi[2], 32'd0);
      phi = phi_tp;

      // start while busy: during DATA and on the tlast cycle
      begin
         int f0;
         f0 = frames_done;
         run_frame(0, 2, 5);
         run_frame(0, 4, 0);
         repeat (20) @(posedge clk);
         #1;
         chk("busy_frames", 32'(frames_done - f0), 32'd2);
         chk("busy_idle", {31'd0, tvalid}, 32'd0);
      end

      // randomized frames with random backpressure and mid-frame input changes
      for (int n = 0; n < 24; n++) begin
         phi        = {$urandom, $urandom};
         pi         = {$urandom, $urandom};
         e          = {$urandom, $urandom};
         trinity    = {$urandom, $urandom};
         phoenix_id = $urandom;
         run_frame(2, (n % 3 == 0) ? 1 : 0, $urandom_range(1, NW - 1));
      end

      // sequence wrap
      begin
         int guard;
         guard = 0;
         while (seq_num != 8'd0 && guard < 300) begin
            run_frame(0, 0, 0);
            guard++;
         end
         chk("wrap_guard", {31'd0, guard >= 300}, 32'd0);
         chk("wrap_last_hdr", last_hdr, 32'h0AC0FF09);
         got_hi.delete(); got_lo.delete();
         run_frame(2, 0, 0);
         if (got_hi.size() > 0) chk("wrap_hdr", got_hi[0], 32'h0AC00009);
      end

      // reset mid-frame at DATA index 5
      run_frame(0, 3, 6);
      got_hi.delete(); got_lo.delete();
      run_frame(0, 0, 0);
      if (got_hi.size() > 0) chk("post_rst_hdr", got_hi[0], 32'h0AC00009);
      chk("post_rst_len", 32'(got_hi.size()), 32'(NW));

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/oak_const_streamer.md
Name: oak_const_streamer

Overview:
- Downstream consumer of the L1 constant-root module: takes its five constant outputs (phi, pi, e, trinity, phoenix_id) and serialises them into framed 32-bit words on a valid/ready stream.
- Feeds the host/link side of the fabric.
- Snapshots the constants at frame start, so a frame is never torn.
- Each frame carries a header with magic number, sequence number and length, then the data words, then an XOR checksum.

Parameters:
- MAGIC, 16'h0AC0, upper 16 bits of the header word.
- HI_FIRST, 1, 1 = upper 32 bits of each 64-bit constant sent first; 0 = lower 32 bits first.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- phi  in  64  IEEE-754 double from the L1 constant module.
- pi  in  64  as above.
- e  in  64  as above.
- trinity  in  64  as above.
- phoenix_id  in  32  32-bit identifier.
- start  in  1  single-cycle request to emit one frame.
- tdata  out  32  stream word.
- tvalid  out  1  tdata valid.
- tready  in  1  sink accepts the word when tvalid && tready.
- tlast  out  1  marks the final word of the frame.
- busy  out  1  high from the cycle after start is accepted until the cycle after the last handshake.
- frame_done  out  1  one-cycle pulse in the cycle after the tlast handshake.
- seq_num  out  8  sequence number of the next frame to be sent.

Behaviour:
- Reset (async, immediate): tvalid=0, tlast=0, tdata=0, busy=0, frame_done=0, seq_num=0, FSM=IDLE, snapshot registers=0.
- FSM states: IDLE, HDR, DATA, CSUM.
- IDLE:
  - start=1 captures all five inputs into snapshot registers, clears the checksum accumulator and moves to HDR.
  - tvalid rises the next cycle (1-cycle latency from start).
  - start is ignored whenever busy=1, including the cycle of the final handshake.
- HDR:
  - tdata = {MAGIC, seq_num, 8'd9}.
  - On handshake go to DATA with word index 0.
  - The header is not included in the checksum.
- DATA:
  - 9 words, index 0..8.
  - Order with HI_FIRST=1: phi[63:32], phi[31:0], pi hi, pi lo, e hi, e lo, trinity hi, trinity lo, phoenix_id. With HI_FIRST=0 the hi/lo halves of each 64-bit constant are swapped.
  - Each accepted word is XORed into the checksum.
  - After the handshake of index 8, go to CSUM (or end the frame; see Optional Feature).
- CSUM:
  - tdata = XOR of the 9 data words, tlast=1.
  - On handshake go to IDLE, pulse frame_done, and increment seq_num (wraps 255 -> 0).
- Handshake rules (AXI-Stream style):
  - Once tvalid=1, tdata and tlast hold stable until tready=1.
  - tvalid never drops without a handshake, except on reset.
  - tready may toggle arbitrarily; back-to-back handshakes sustain one word per cycle.
- Input stability: changes on the constant inputs mid-frame have no effect on the frame in flight.
- Reset mid-frame: the frame is abandoned with no tlast and seq_num returns to 0; the next start begins a fresh frame.

Optional Feature:
- Macro: OAK_STREAM_CSUM_EN.
- Defined: frame is header + 9 data + checksum = 11 words; tlast on the checksum word; header length field = 9.
- Undefined: CSUM state and checksum logic are removed; frame is 10 words; tlast on data index 8; frame_done and seq_num update on that handshake; header length field stays 9.

Test Plan:
- Reset, then start with tready=1 held high and inputs phi=3FF9E3779B97F4A8, pi=400921FB54442D18, e=4005BF0A8B145769, trinity=4008000000000000, phoenix_id=000003E7:
  - Words: 0AC00009, 3FF9E377, 9B97F4A8, 400921FB, 54442D18, 4005BF0A, 8B145769, 40080000, 00000000, 000003E7, then 3B3AF0B8 with tlast=1.
  - frame_done pulses once; seq_num becomes 1.
- Backpressure: tready toggles 1,0,0,1 repeatedly -> tdata stable through every stall, same 11 words in order, no drops or duplicates.
- Snapshot: change phi to 0 at DATA index 3 -> the frame still carries 3FF9E377/9B97F4A8; the next frame carries 00000000/00000000.
- Start while busy plus seq_num wrap:
  - A start pulse during DATA and on the tlast cycle -> ignored; exactly one frame emitted.
  - Run 256 frames -> header byte sequence 00..FF, then 00.
- Reset mid-frame: assert rst at DATA index 5 -> tvalid=0 immediately, seq_num=0; the following start emits header 0AC00009.
- HI_FIRST=0 and OAK_STREAM_CSUM_EN undefined: second word is 9B97F4A8; the 10th word is 000003E7 with tlast=1; no checksum word.
